// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter family.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        BND_WRAP = 1'b0,
        BND_SAT  = 1'b1
    } bound_e;

    // Top count value (modulus - 1), masked to the counter width.
    function automatic logic [63:0] max_count(input int modulus, input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (64'(modulus) - 64'd1) & mask;
    endfunction

endpackage

// File: rtl/nreg.sv
// WIDTH-bit D register with asynchronous active-low reset to zero.
module nreg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with load, clear, run-time wrap/saturate,
// registered wrap pulse and sticky overflow flag.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             ovf
);

    generate
        if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
            $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(max_count(MODULUS, WIDTH));
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_ovf_next;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_d_ok;
    dir_e             w_dir;
    bound_e           w_bnd;

    assign w_dir    = dir_e'(up);
    assign w_bnd    = bound_e'(sat);
    assign w_at_top = (r_q == MAX_Q);
    assign w_at_bot = (r_q == '0);
    // Widened compare so MODULUS == 2**WIDTH still fits.
    assign w_d_ok   = ({1'b0, d} < MOD_EXT);

    // NOTE: defaults first so every path assigns every output (no latches).
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        w_ovf_next  = r_ovf;

        if (clr) begin
            w_q_next   = '0;
            w_ovf_next = 1'b0;
        end else if (load) begin
            if (w_d_ok) begin
                w_q_next = d;
            end else begin
                w_q_next   = MAX_Q;
                w_ovf_next = 1'b1;
            end
        end else if (en) begin
            if (w_dir == DIR_UP) begin
                if (!w_at_top) begin
                    w_q_next = r_q + WIDTH'(1);
                end else begin
                    w_ovf_next = 1'b1;
                    if (w_bnd == BND_WRAP) begin
                        w_q_next    = '0;
                        w_wrap_next = 1'b1;
                    end
                end
            end else begin
                if (!w_at_bot) begin
                    w_q_next = r_q - WIDTH'(1);
                end else begin
                    w_ovf_next = 1'b1;
                    if (w_bnd == BND_WRAP) begin
                        w_q_next    = MAX_Q;
                        w_wrap_next = 1'b1;
                    end
                end
            end
        end
    end

    nreg #(.WIDTH(WIDTH)) u_q_reg (
        .clk  (clk),
        .rst_n(reset),
        .i_d  (w_q_next),
        .o_q  (r_q)
    );

    nreg #(.WIDTH(1)) u_wrap_reg (
        .clk  (clk),
        .rst_n(reset),
        .i_d  (w_wrap_next),
        .o_q  (r_wrap)
    );

    nreg #(.WIDTH(1)) u_ovf_reg (
        .clk  (clk),
        .rst_n(reset),
        .i_d  (w_ovf_next),
        .o_q  (r_ovf)
    );

    assign q    = r_q;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

endmodule
